xgmii_rx_port_select: RTL and testbench

Parametrised N-port XGMII receive selector that replaces the fixed "port 0 feeds the app" wiring in the 10G top level. It picks one of NPORTS PHY receive streams and forwards it to the single app XGMII RX input. Port changes happen only on frame boundaries, and in auto mode it fails over on link loss. Output is registered: one xgmii_clk (156.25 MHz) cycle of latency.

---
 rtl/xgmii_rx_port_select.sv | 159 +++++++++++++++
 tb/tb_xgmii_rx_port_select.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_rx_port_select.sv
// N-port XGMII receive selector: forwards one PHY RX stream to the app with one cycle of latency.
// Port changes happen on frame boundaries, or immediately (with ABORT) when the current port dies.
module xgmii_rx_port_select #(
  parameter int NPORTS = 4,
  parameter int SELW   = 2,
  parameter int CNT_W  = 16
) (
  input  logic                  xgmii_clk,
  input  logic                  sys_rst,
  input  logic [64*NPORTS-1:0]  xgmii_rxd_in,
  input  logic [8*NPORTS-1:0]   xgmii_rxc_in,
  input  logic [NPORTS-1:0]     link_up,
  input  logic [NPORTS-1:0]     port_en,
  input  logic                  auto_mode,
  input  logic [SELW-1:0]       manual_sel,
  output logic [63:0]           xgmii_rxd,
  output logic [7:0]            xgmii_rxc,
  output logic [SELW-1:0]       sel_port,
  output logic                  suppress,
  output logic [CNT_W-1:0]      switch_cnt,
  output logic [CNT_W-1:0]      abort_cnt
);

  localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
  localparam logic [63:0] ABORT_D = 64'h07070707070707FE;
  localparam logic [7:0]  CTRL_C  = 8'hFF;

  logic [NPORTS-1:0] in_frame_q, in_frame_d, has_start;
  logic [NPORTS-1:0] eligible;
  logic [63:0]       cur_d;
  logic [7:0]        cur_c;
  logic              cur_ok, cur_in_frame_q, cur_in_frame_d, cur_start;
  logic              found;
  logic [SELW-1:0]   first_idx, target;
  logic              tgt_in_frame_d;
  logic [SELW-1:0]   nxt_sel;
  logic              nxt_sup, sw_inc, ab_inc;
  logic [63:0]       nxt_d;
  logic [7:0]        nxt_c;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    in_frame_d = in_frame_q;
    has_start  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      // Ascending lane order lets the highest lane's start/terminate decide.
      for (int l = 0; l < 8; l++) begin
        if (xgmii_rxc_in[8*p+l]) begin
          if (xgmii_rxd_in[64*p+8*l +: 8] == 8'hFB) begin
            in_frame_d[p] = 1'b1;
            has_start[p]  = 1'b1;
          end else if (xgmii_rxd_in[64*p+8*l +: 8] == 8'hFD ||
                       xgmii_rxd_in[64*p+8*l +: 8] == 8'hFE) begin
            in_frame_d[p] = 1'b0;
          end
        end
      end
    end
  end

  assign eligible = port_en & link_up;

  always_comb begin
    cur_d          = IDLE_D;
    cur_c          = CTRL_C;
    cur_ok         = 1'b0;
    cur_in_frame_q = 1'b0;
    cur_in_frame_d = 1'b0;
    cur_start      = 1'b0;
    found          = 1'b0;
    first_idx      = sel_port;
    for (int p = 0; p < NPORTS; p++) begin
      if (SELW'(p) == sel_port) begin
        cur_d          = xgmii_rxd_in[64*p +: 64];
        cur_c          = xgmii_rxc_in[8*p +: 8];
        cur_ok         = eligible[p];
        cur_in_frame_q = in_frame_q[p];
        cur_in_frame_d = in_frame_d[p];
        cur_start      = has_start[p];
      end
    end
    for (int p = NPORTS - 1; p >= 0; p--) begin
      if (eligible[p]) begin
        found     = 1'b1;
        first_idx = SELW'(p);
      end
    end
  end

  always_comb begin
    target = sel_port;
    if (!auto_mode) begin
      if (int'(manual_sel) < NPORTS) target = manual_sel;
    end else if (!cur_ok && found) begin
      target = first_idx;
    end
    tgt_in_frame_d = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      if (SELW'(p) == target) tgt_in_frame_d = in_frame_d[p];
    end
  end

  always_comb begin
    nxt_sel = sel_port;
    nxt_sup = suppress;
    nxt_d   = IDLE_D;
    nxt_c   = CTRL_C;
    sw_inc  = 1'b0;
    ab_inc  = 1'b0;
    if (target != sel_port && !cur_ok) begin
      // Current port is dead: leave it now, terminating any frame it was carrying.
      nxt_sel = target;
      sw_inc  = 1'b1;
      nxt_sup = tgt_in_frame_d;
      if (cur_in_frame_q) begin
        nxt_d  = ABORT_D;
        ab_inc = 1'b1;
      end
    end else if (!cur_ok) begin
      nxt_sup = 1'b1;
    end else if (target != sel_port && !cur_in_frame_d && !cur_start) begin
      nxt_sel = target;
      sw_inc  = 1'b1;
      nxt_sup = tgt_in_frame_d;
      if (!suppress) begin
        nxt_d = cur_d;
        nxt_c = cur_c;
      end
    end else if (suppress) begin
      // The boundary word itself stays idle; forwarding resumes on the next word.
      nxt_sup = cur_in_frame_d;
    end else begin
      nxt_d = cur_d;
      nxt_c = cur_c;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge xgmii_clk or posedge sys_rst) begin
    if (sys_rst) begin
      in_frame_q <= '0;
      sel_port   <= '0;
      suppress   <= 1'b1;
      xgmii_rxd  <= IDLE_D;
      xgmii_rxc  <= CTRL_C;
      switch_cnt <= '0;
      abort_cnt  <= '0;
    end else begin
      in_frame_q <= in_frame_d;
      sel_port   <= nxt_sel;
      suppress   <= nxt_sup;
      xgmii_rxd  <= nxt_d;
      xgmii_rxc  <= nxt_c;
      if (sw_inc) switch_cnt <= switch_cnt + CNT_W'(1);
      if (ab_inc) abort_cnt  <= abort_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_xgmii_rx_port_select.sv
// Directed bench for xgmii_rx_port_select (4 ports, 4-bit counters so wrap is reachable).
module tb_xgmii_rx_port_select;

  localparam int NPORTS = 4;
  localparam int SELW   = 2;
  localparam int CNT_W  = 4;

  localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
  localparam logic [63:0] ABORT_D = 64'h07070707070707FE;
  localparam logic [63:0] SOF_D   = 64'hD5555555555555FB;
  localparam logic [7:0]  SOF_C   = 8'h01;
  localparam logic [63:0] EOF_D   = 64'h07070707FDCCBBAA;
  localparam logic [7:0]  EOF_C   = 8'hF8;

  logic                 xgmii_clk = 1'b0;
  logic                 sys_rst   = 1'b1;
  logic [63:0]          rxd_w [NPORTS];
  logic [7:0]           rxc_w [NPORTS];
  logic [64*NPORTS-1:0] xgmii_rxd_in;
  logic [8*NPORTS-1:0]  xgmii_rxc_in;
  logic [NPORTS-1:0]    link_up, port_en;
  logic                 auto_mode;
  logic [SELW-1:0]      manual_sel;
  logic [63:0]          xgmii_rxd;
  logic [7:0]           xgmii_rxc;
  logic [SELW-1:0]      sel_port;
  logic                 suppress;
  logic [CNT_W-1:0]     switch_cnt, abort_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 xgmii_clk = ~xgmii_clk;

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      xgmii_rxd_in[64*p +: 64] = rxd_w[p];
      xgmii_rxc_in[8*p +: 8]   = rxc_w[p];
    end
  end

  xgmii_rx_port_select #(.NPORTS(NPORTS), .SELW(SELW), .CNT_W(CNT_W)) dut (
    .xgmii_clk    (xgmii_clk),
    .sys_rst      (sys_rst),
    .xgmii_rxd_in (xgmii_rxd_in),
    .xgmii_rxc_in (xgmii_rxc_in),
    .link_up      (link_up),
    .port_en      (port_en),
    .auto_mode    (auto_mode),
    .manual_sel   (manual_sel),
    .xgmii_rxd    (xgmii_rxd),
    .xgmii_rxc    (xgmii_rxc),
    .sel_port     (sel_port),
    .suppress     (suppress),
    .switch_cnt   (switch_cnt),
    .abort_cnt    (abort_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge xgmii_clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [63:0] d, input logic [7:0] c);
    rxd_w[p] = d;
    rxc_w[p] = c;
  endtask

  task automatic check_out(input string tag, input logic [63:0] d, input logic [7:0] c);
    check({tag, ".rxd"}, xgmii_rxd, d);
    check({tag, ".rxc"}, {56'd0, xgmii_rxc}, {56'd0, c});
  endtask

  // Reset with all ports idle and eligible; leaves suppress cleared by one idle word.
  task automatic do_reset(input logic amode);
    sys_rst = 1'b1;
    for (int p = 0; p < NPORTS; p++) set_port(p, IDLE_D, 8'hFF);
    link_up    = 4'hF;
    port_en    = 4'hF;
    auto_mode  = amode;
    manual_sel = '0;
    step();
    sys_rst = 1'b0;
    step();
  endtask

  initial begin
    for (int p = 0; p < NPORTS; p++) set_port(p, IDLE_D, 8'hFF);
    link_up = 4'hF; port_en = 4'hF; auto_mode = 1'b1; manual_sel = '0;

    // 1: reset values, suppress release, one-cycle latency
    step();
    check_out("rst", IDLE_D, 8'hFF);
    check("rst.sel", sel_port, 0);
    check("rst.sup", suppress, 1);
    check("rst.swc", switch_cnt, 0);
    check("rst.abc", abort_cnt, 0);
    sys_rst = 1'b0;
    step();
    check("t1.sup_fall", suppress, 0);
    check_out("t1.boundary_idle", IDLE_D, 8'hFF);
    set_port(0, 64'h1122334455667788, 8'h00);
    step();
    check_out("t1.fwd", 64'h1122334455667788, 8'h00);
    set_port(0, 64'h99AABBCCDDEEFF00, 8'h00);
    #2;
    check_out("t1.hold", 64'h1122334455667788, 8'h00);
    step();
    check_out("t1.fwd2", 64'h99AABBCCDDEEFF00, 8'h00);

    // 2: manual switch waits for end of frame on port 0
    do_reset(1'b0);
    set_port(2, 64'h2222222222222222, 8'h00);
    set_port(0, SOF_D, SOF_C);
    step();
    check_out("t2.sof", SOF_D, SOF_C);
    manual_sel = 2'd2;
    set_port(0, 64'h0102030405060708, 8'h00);
    step();
    check("t2.sel_hold", sel_port, 0);
    check_out("t2.data", 64'h0102030405060708, 8'h00);
    set_port(0, EOF_D, EOF_C);
    step();
    check("t2.sel_sw", sel_port, 2);
    check_out("t2.eof", EOF_D, EOF_C);
    check("t2.swc", switch_cnt, 1);
    check("t2.sup", suppress, 0);
    step();
    check_out("t2.port2", 64'h2222222222222222, 8'h00);

    // 3: link loss mid-frame forces ABORT and failover to port 1
    do_reset(1'b1);
    set_port(0, SOF_D, SOF_C);
    step();
    check_out("t3.sof", SOF_D, SOF_C);
    set_port(0, 64'h0A0B0C0D0E0F1011, 8'h00);
    link_up = 4'hE;
    step();
    check_out("t3.abort", ABORT_D, 8'hFF);
    check("t3.sel", sel_port, 1);
    check("t3.abc", abort_cnt, 1);
    check("t3.swc", switch_cnt, 1);

    // 4: landing on port 1 mid-frame suppresses until its terminate
    do_reset(1'b1);
    set_port(1, SOF_D, SOF_C);
    step();
    set_port(1, 64'h3333333333333333, 8'h00);
    link_up = 4'hE;
    step();
    check("t4.sel", sel_port, 1);
    check("t4.sup_on", suppress, 1);
    check_out("t4.idle0", IDLE_D, 8'hFF);
    check("t4.abc", abort_cnt, 0);
    set_port(1, 64'h4444444444444444, 8'h00);
    step();
    check_out("t4.idle1", IDLE_D, 8'hFF);
    check("t4.sup_mid", suppress, 1);
    set_port(1, EOF_D, EOF_C);
    step();
    check_out("t4.eof_dropped", IDLE_D, 8'hFF);
    check("t4.sup_off", suppress, 0);
    set_port(1, SOF_D, SOF_C);
    step();
    check_out("t4.sof", SOF_D, SOF_C);
    set_port(1, 64'h5555AAAA5555AAAA, 8'h00);
    step();
    check_out("t4.data", 64'h5555AAAA5555AAAA, 8'h00);
    set_port(1, EOF_D, EOF_C);
    step();
    check_out("t4.eof", EOF_D, EOF_C);

    // 5: no eligible port, then port 3 returns
    do_reset(1'b1);
    link_up = 4'h0;
    set_port(0, 64'h6666666666666666, 8'h00);
    step();
    check("t5.sel", sel_port, 0);
    check("t5.sup", suppress, 1);
    check_out("t5.idle", IDLE_D, 8'hFF);
    step();
    check_out("t5.idle2", IDLE_D, 8'hFF);
    link_up = 4'h8;
    set_port(3, 64'h7777777777777777, 8'h00);
    step();
    check("t5.sel3", sel_port, 3);
    check("t5.swc", switch_cnt, 1);
    step();
    check_out("t5.fwd3", 64'h7777777777777777, 8'h00);

    // 6: switch counter wrap, then async reset mid-frame
    do_reset(1'b0);
    for (int i = 0; i < 17; i++) begin
      manual_sel = (i % 2 == 0) ? 2'd1 : 2'd0;
      step();
      if (i == 15) check("t6.wrap0", switch_cnt, 0);
    end
    check("t6.wrap1", switch_cnt, 1);
    check("t6.sel", sel_port, 1);
    set_port(1, SOF_D, SOF_C);
    step();
    check_out("t6.sof", SOF_D, SOF_C);
    set_port(1, 64'h8888888888888888, 8'h00);
    #2;
    sys_rst = 1'b1;
    #1;
    check_out("t6.rst", IDLE_D, 8'hFF);
    check("t6.rst.sel", sel_port, 0);
    check("t6.rst.sup", suppress, 1);
    check("t6.rst.swc", switch_cnt, 0);
    check("t6.rst.abc", abort_cnt, 0);
    step();
    sys_rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
